// File: rtl/bram18k_sdp_burst_reader.sv
// Burst read engine for the registered read port of an 18K simple-dual-port RAM.
// Issues credit-limited reads and streams returned words out of a 4-entry FIFO.
module bram18k_sdp_burst_reader #(
  parameter int ADDR_WIDTH = 10,
  parameter int DATA_WIDTH = 18
) (
  input  logic                  clock0,
  input  logic                  reset,
  input  logic                  START_i,
  input  logic [ADDR_WIDTH-1:0] BASE_ADDR_i,
  input  logic [ADDR_WIDTH:0]   LEN_i,
  output logic                  REN_o,
  output logic [ADDR_WIDTH-1:0] RD_ADDR_o,
  input  logic [DATA_WIDTH-1:0] RDATA_i,
  output logic                  VALID_o,
  input  logic                  READY_i,
  output logic [DATA_WIDTH-1:0] DATA_o,
  output logic                  LAST_o,
  output logic                  BUSY_o,
  output logic                  DONE_o
);

  typedef enum logic [1:0] {S_IDLE, S_RUN, S_DRAIN} state_t;

  localparam logic [ADDR_WIDTH-1:0] ADDR_ONE = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ONE  = 1;
  localparam logic [ADDR_WIDTH:0]   LEN_ZERO = 0;

  state_t                  r_state;
  logic                    r_ren;
  logic                    r_ren_d;
  logic [ADDR_WIDTH-1:0]   r_addr;
  logic [ADDR_WIDTH-1:0]   r_next_addr;
  logic [ADDR_WIDTH:0]     r_remaining;
  logic [ADDR_WIDTH:0]     r_len;
  logic [ADDR_WIDTH:0]     r_sent;
  logic                    r_done;
  logic [DATA_WIDTH-1:0]   r_mem [4];
  logic [1:0]              r_wptr;
  logic [1:0]              r_rptr;
  logic [2:0]              r_count;

  logic                    w_push;
  logic                    w_pop;
  logic [1:0]              w_inflight;
  logic                    w_credit;
  logic                    w_issue;
  logic [2:0]              w_count_nxt;

  // REN_o is asserted for the cycle after the issuing edge, so the credit
  // check counts both the read on the port now and the one being written.
  assign w_push      = r_ren_d;
  assign w_pop       = (r_count != 3'd0) && READY_i;
  assign w_inflight  = {1'b0, r_ren} + {1'b0, r_ren_d};
  assign w_credit    = ({1'b0, r_count} + {2'b00, w_inflight}) < 4'd4;
  assign w_issue     = (r_state == S_RUN) && (r_remaining != LEN_ZERO) && w_credit;
  assign w_count_nxt = r_count + {2'b00, w_push} - {2'b00, w_pop};

  always_ff @(posedge clock0 or posedge reset) begin
    if (reset) begin
      r_state     <= S_IDLE;
      r_ren       <= 1'b0;
      r_ren_d     <= 1'b0;
      r_addr      <= '0;
      r_next_addr <= '0;
      r_remaining <= '0;
      r_len       <= '0;
      r_sent      <= '0;
      r_done      <= 1'b0;
      r_wptr      <= '0;
      r_rptr      <= '0;
      r_count     <= '0;
    end else begin
      r_ren_d <= r_ren;
      r_done  <= 1'b0;
      r_count <= w_count_nxt;
      if (w_push) r_wptr <= r_wptr + 2'd1;
      if (w_pop) begin
        r_rptr <= r_rptr + 2'd1;
        r_sent <= r_sent + LEN_ONE;
      end
      case (r_state)
        S_IDLE: begin
          r_ren <= 1'b0;
          if (START_i) begin
            if (LEN_i == LEN_ZERO) begin
              r_done <= 1'b1;
            end else begin
              r_ren       <= 1'b1;
              r_addr      <= BASE_ADDR_i;
              r_next_addr <= BASE_ADDR_i + ADDR_ONE;
              r_remaining <= LEN_i - LEN_ONE;
              r_len       <= LEN_i;
              r_sent      <= '0;
              r_state     <= (LEN_i == LEN_ONE) ? S_DRAIN : S_RUN;
            end
          end
        end
        S_RUN: begin
          r_ren <= w_issue;
          if (w_issue) begin
            r_addr      <= r_next_addr;
            r_next_addr <= r_next_addr + ADDR_ONE;
            r_remaining <= r_remaining - LEN_ONE;
            if (r_remaining == LEN_ONE) r_state <= S_DRAIN;
          end
        end
        S_DRAIN: begin
          r_ren <= 1'b0;
          if (!r_ren && (w_count_nxt == 3'd0)) begin
            r_done  <= 1'b1;
            r_state <= S_IDLE;
          end
        end
        default: begin
          r_ren   <= 1'b0;
          r_state <= S_IDLE;
        end
      endcase
    end
  end

  // FIFO storage carries data only; occupancy lives in the control registers.
  always_ff @(posedge clock0) begin
    if (w_push) r_mem[r_wptr] <= RDATA_i;
  end

  assert property (@(posedge clock0) disable iff (reset)
    !(w_push && !w_pop && (r_count == 3'd4)));

  assign REN_o     = r_ren;
  assign RD_ADDR_o = r_addr;
  assign VALID_o   = (r_count != 3'd0);
  assign DATA_o    = VALID_o ? r_mem[r_rptr] : '0;
  assign LAST_o    = VALID_o && (r_sent == (r_len - LEN_ONE));
  assign BUSY_o    = (r_state != S_IDLE);
  assign DONE_o    = r_done;

endmodule

// File: doc/bram18k_sdp_burst_reader.md
# bram18k_sdp_burst_reader

Burst read engine for the read port of an 18K simple-dual-port block RAM. It takes a base address and word count, then issues `REN_o`/`RD_ADDR_o` to the RAM's registered read port. Returned words go into an internal 4-entry FIFO and leave as a valid/ready stream with a last-word marker. It is the read-side counterpart to the write-port wrappers and shares the RAM's read clock.

## Interface
- `ADDR_WIDTH`, default 10: RAM read address width; addresses wrap modulo 2^ADDR_WIDTH.
- `DATA_WIDTH`, default 18: RAM read data width.
- `clock0`, input, 1: sole clock; also drives the RAM `RD_CLK_i`.
- `reset`, input, 1: asynchronous, active-high reset.
- `START_i`, input, 1: burst request; sampled only in IDLE.
- `BASE_ADDR_i`, input, ADDR_WIDTH: first address; latched on accepted START.
- `LEN_i`, input, ADDR_WIDTH+1: word count, 0..2^ADDR_WIDTH; latched on accepted START.
- `REN_o`, output, 1: RAM read enable (registered).
- `RD_ADDR_o`, output, ADDR_WIDTH: RAM read address (registered).
- `RDATA_i`, input, DATA_WIDTH: RAM read data; valid in the cycle after the cycle in which `REN_o` was high.
- `VALID_o`, output, 1: stream word available.
- `READY_i`, input, 1: stream sink accepts; a transfer occurs when `VALID_o && READY_i` at a clock edge.
- `DATA_o`, output, DATA_WIDTH: stream word (FIFO head).
- `LAST_o`, output, 1: `DATA_o` is the final word of the burst; qualified by `VALID_o`.
- `BUSY_o`, output, 1: high in RUN and DRAIN.
- `DONE_o`, output, 1: one-cycle pulse when a burst completes.

## Operation
- States: IDLE, RUN, DRAIN.
- IDLE, `START_i`=1, `LEN_i`>0: latch the address, set `remaining`=`LEN_i` and `sent`=0, go to RUN.
- IDLE, `START_i`=1, `LEN_i`=0: no RAM access; `DONE_o` pulses in the next cycle; stay in IDLE.
- `START_i` is ignored outside IDLE.
- RUN, read issue: in a cycle with `remaining`>0 and `fifo_count + inflight < 4`:
  - drive `REN_o`=1 with the current address;
  - then increment the address with wrap and decrement `remaining`.
  - Otherwise `REN_o`=0 and `RD_ADDR_o` holds.
- RUN exits to DRAIN after the edge that issues the last read.
- `inflight` counts issued reads whose data is not yet written to the FIFO (0..2). In the cycle after each `REN_o`=1 cycle, `RDATA_i` is written to the FIFO.
- The credit check uses register values at the start of the cycle and does not count a same-cycle pop.
- DRAIN, exit: when `inflight`=0, FIFO empty and `remaining`=0, pulse `DONE_o` for one cycle and go to IDLE.
- FIFO: 4 entries, simultaneous push and pop allowed. The credit rule guarantees it never overflows; an overflow is an assertion failure.
- `LAST_o`=1 when the head word index (`sent`) equals LEN−1. `sent` increments on each transfer.
- `DATA_o` and `LAST_o` are stable while `VALID_o && !READY_i`.
- Reset, including mid-burst: state goes to IDLE. Clear FIFO, `inflight`, counters and all outputs. RAM data that arrives after reset is discarded.
- Reset values: `REN_o`=0, `RD_ADDR_o`=0, `VALID_o`=0, `DATA_o`=0, `LAST_o`=0, `BUSY_o`=0, `DONE_o`=0.

## Timing
- START sampled at edge 0; `REN_o`=1 with `RD_ADDR_o`=BASE during cycle 1.
- `RDATA_i` is valid in cycle 2 and written to the FIFO at edge 3; `VALID_o`=1 from cycle 3. First-word latency is 3 cycles.
- With `READY_i` held high, one read is issued and one word transferred every cycle (steady state: `fifo_count`=1, `inflight`=2).
- With `READY_i` held low, issue stalls after 4 outstanding words (FIFO plus inflight). Issue resumes in the cycle after the first pop frees a credit.
- `DONE_o` pulses the cycle after the final transfer's edge; `BUSY_o` falls in that same cycle.
- A new START is accepted in the first IDLE cycle, which is the `DONE_o` cycle.

## Test plan
- Single read: BASE=5, LEN=1, RAM[5]=0x2A5A3, READY=1 → `REN_o` in cycle 1, address 5; `VALID_o`, `LAST_o`, `DATA_o`=0x2A5A3 in cycle 3; `DONE_o` in cycle 4.
- Full-rate burst: BASE=0, LEN=8, RAM[i]=i, READY=1 → data 0..7 on cycles 3..10, `LAST_o` only with 7, exactly 8 `REN_o` cycles back to back.
- Backpressure: LEN=8, READY=0 cycles 0–12, then 1 → exactly 4 `REN_o` pulses before release; no word lost or duplicated; `DATA_o` stable while stalled; output sequence 0..7.
- Wrap and length corners:
  - BASE=1022, LEN=4 → addresses 1022, 1023, 0, 1.
  - LEN=1024 → 1024 words, `LAST_o` once.
  - LEN=0 → no `REN_o`, `DONE_o` the next cycle.
- START while busy: second START mid-burst with different BASE → ignored; the original burst completes unchanged.
- Reset at cycle 5 of an 8-word burst → all outputs 0 immediately; late `RDATA_i` not emitted. A fresh burst after reset is correct from word 0.
